axi_cdma_desc_seg: RTL
======================

AXI_CDMA_DESC_SEG -- requirements
Module: axi_cdma_desc_seg

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 16, byte address width.
REQ-002 SHALL have parameter LEN_WIDTH, default 20, byte length width.
REQ-003 SHALL have parameter TAG_WIDTH, default 8, requester tag width.
REQ-004 SHALL have parameter SEG_LEN, default 4096, maximum segment bytes; power of two, less than 2^LEN_WIDTH.
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 4, maximum segments in flight at the core; power of two, 1..16.
REQ-006 SHALL have parameter M_TAG_WIDTH, default 8, core tag width.
REQ-007 clk  in  1  clock; reset rst, synchronous, active-high.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 s_axis_desc_read_addr / s_axis_desc_write_addr  in  AXI_ADDR_WIDTH each  input descriptor source and destination.
REQ-010 s_axis_desc_len  in  LEN_WIDTH  input byte count; s_axis_desc_tag  in  TAG_WIDTH  input tag.
REQ-011 s_axis_desc_valid  in  1 / s_axis_desc_ready  out  1  input handshake.
REQ-012 m_axis_desc_read_addr / m_axis_desc_write_addr  out  AXI_ADDR_WIDTH each  segment addresses to the core.
REQ-013 m_axis_desc_len  out  LEN_WIDTH; m_axis_desc_tag  out  M_TAG_WIDTH  segment index modulo 2^M_TAG_WIDTH.
REQ-014 m_axis_desc_valid  out  1 / m_axis_desc_ready  in  1  segment handshake.
REQ-015 s_axis_desc_status_tag  in  M_TAG_WIDTH / s_axis_desc_status_valid  in  1  segment completion from the core.
REQ-016 m_axis_desc_status_tag  out  TAG_WIDTH / m_axis_desc_status_valid  out  1  whole-descriptor completion.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 SHALL implement FSM IDLE, ISSUE, DRAIN, STATUS.
REQ-019 IDLE: s_axis_desc_ready=1; on handshake SHALL latch addresses, len, and tag, and clear the segment index; next state is ISSUE if len>0, otherwise STATUS.
REQ-020 In all other states, s_axis_desc_ready SHALL be 0: exactly one descriptor is processed at a time.
REQ-021 ISSUE: segment length SHALL be min(remaining, SEG_LEN), with no alignment splitting.
REQ-022 ISSUE: m_axis_desc_valid and all m_axis_desc fields SHALL be registered outputs; the first segment presents valid in the cycle after input acceptance.
REQ-023 A new segment SHALL be presented only while outstanding < MAX_OUTSTANDING.
REQ-024 Once asserted, m_axis_desc_valid and all m_axis_desc fields SHALL hold stable until m_axis_desc_ready is high.
REQ-025 On each segment handshake, both addresses SHALL advance by the segment length (modulo 2^AXI_ADDR_WIDTH, wrap permitted), remaining SHALL decrease by the segment length, the segment index SHALL increment, and outstanding SHALL increment.
REQ-026 A handshake that leaves remaining=0 SHALL move the FSM to DRAIN.
REQ-027 Back-to-back segments SHALL issue at 1 per cycle while the core is ready and the outstanding limit is not reached.
REQ-028 Each s_axis_desc_status_valid SHALL decrement outstanding in any state; the status tag value is ignored.
REQ-029 A completion with outstanding=0 SHALL be ignored, with no underflow.
REQ-030 A segment handshake and a completion in the same cycle SHALL leave outstanding unchanged.
REQ-031 outstanding SHALL be $clog2(MAX_OUTSTANDING)+1 bits wide and never exceed MAX_OUTSTANDING.
REQ-032 DRAIN: the FSM SHALL move to STATUS in the cycle after outstanding reaches 0, including when the last completion coincides with DRAIN entry.
REQ-033 STATUS: m_axis_desc_status_valid SHALL pulse high for exactly one cycle with the latched tag, then the FSM SHALL return to IDLE.
REQ-034 m_axis_desc_status_tag SHALL hold its last value when m_axis_desc_status_valid is low.

Reset
REQ-035 On rst, the FSM SHALL go to IDLE.
REQ-036 On rst, outstanding, the segment index, m_axis_desc_valid, m_axis_desc_status_valid, and busy SHALL be 0, and s_axis_desc_ready SHALL be 1 from the first cycle after reset.
REQ-037 Reset mid-operation SHALL abandon the descriptor without a status pulse; completions for segments already issued SHALL be absorbed by REQ-029.
REQ-038 Datapath registers SHALL need no reset.

Structure
REQ-039 FSM state encoding and the defaults of SEG_LEN and MAX_OUTSTANDING SHALL reside in the shared package axi_cdma_pkg.
REQ-040 The outstanding up/down counter SHALL be a sub-module named axi_cdma_credit_cnt (inc, dec, count, full); all other logic is flat.

Verification
REQ-041 len=10000, SEG_LEN=4096, read 0x1000, write 0x8000, core always ready -> segments (0x1000,0x8000,4096,tag 0), (0x2000,0x9000,4096,tag 1), (0x3000,0xA000,1808,tag 2) on consecutive cycles; after 3 completions, one status pulse with the input tag.
REQ-042 len=0, tag=0x5A -> no segment issued; status pulse with tag 0x5A two cycles after acceptance.
REQ-043 len=8*4096, MAX_OUTSTANDING=4, completions withheld -> exactly 4 segments issue, then valid stays low; each completion releases exactly one more segment.
REQ-044 m_axis_desc_ready held low 5 cycles mid-stream -> fields stable; segments are neither lost nor duplicated; byte total equals len.
REQ-045 Last segment handshake coincides with a completion, and a stray completion arrives in IDLE -> outstanding correct, no underflow, single status pulse.
REQ-046 rst asserted during ISSUE with 2 outstanding -> IDLE next cycle, no status pulse; the next descriptor then completes normally despite late completions.

Source files
------------

// File: rtl/axi_cdma_pkg.sv
// Shared definitions for the CDMA descriptor segmenter: FSM encoding and
// default segmentation limits.
package axi_cdma_pkg;

    localparam int DEFAULT_SEG_LEN         = 4096;
    localparam int DEFAULT_MAX_OUTSTANDING = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_STATUS = 2'd3
    } seg_state_t;

endpackage

// File: rtl/axi_cdma_credit_cnt.sv
// Up/down counter of segments in flight at the core; a decrement at zero is
// dropped so late or stray completions can never underflow it.
module axi_cdma_credit_cnt #(
    parameter int MAX_COUNT = 4,
    parameter int CNT_WIDTH = $clog2(MAX_COUNT) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 dec,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 full
);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;
    logic                 dec_eff;

    assign dec_eff = dec && (count_q != '0);
    assign full    = (count_q == CNT_WIDTH'(MAX_COUNT));
    assign count   = count_q;

    always_comb begin
        count_d = count_q;
        if (inc && !dec_eff && !full) begin
            count_d = count_q + 1'b1;
        end else if (dec_eff && !inc) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/axi_cdma_desc_seg.sv
// Splits one copy descriptor into SEG_LEN-sized segments for the DMA core,
// limits segments in flight, and reports whole-descriptor completion.
module axi_cdma_desc_seg
    import axi_cdma_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH  = 16,
    parameter int LEN_WIDTH       = 20,
    parameter int TAG_WIDTH       = 8,
    parameter int SEG_LEN         = DEFAULT_SEG_LEN,
    parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
    parameter int M_TAG_WIDTH     = 8
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [AXI_ADDR_WIDTH-1:0] s_axis_desc_read_addr,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axis_desc_write_addr,
    input  logic [LEN_WIDTH-1:0]      s_axis_desc_len,
    input  logic [TAG_WIDTH-1:0]      s_axis_desc_tag,
    input  logic                      s_axis_desc_valid,
    output logic                      s_axis_desc_ready,

    output logic [AXI_ADDR_WIDTH-1:0] m_axis_desc_read_addr,
    output logic [AXI_ADDR_WIDTH-1:0] m_axis_desc_write_addr,
    output logic [LEN_WIDTH-1:0]      m_axis_desc_len,
    output logic [M_TAG_WIDTH-1:0]    m_axis_desc_tag,
    output logic                      m_axis_desc_valid,
    input  logic                      m_axis_desc_ready,

    input  logic [M_TAG_WIDTH-1:0]    s_axis_desc_status_tag,
    input  logic                      s_axis_desc_status_valid,

    output logic [TAG_WIDTH-1:0]      m_axis_desc_status_tag,
    output logic                      m_axis_desc_status_valid,

    output logic                      busy
);

    localparam int                   CNT_WIDTH = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [LEN_WIDTH-1:0] SEG_LEN_L = LEN_WIDTH'(SEG_LEN);

    seg_state_t                state_q;
    logic [TAG_WIDTH-1:0]      tag_q;

    // Next segment not yet presented to the core.
    logic [AXI_ADDR_WIDTH-1:0] nxt_rd_q;
    logic [AXI_ADDR_WIDTH-1:0] nxt_wr_q;
    logic [LEN_WIDTH-1:0]      nxt_rem_q;
    logic [M_TAG_WIDTH-1:0]    nxt_idx_q;

    logic [AXI_ADDR_WIDTH-1:0] m_rd_q;
    logic [AXI_ADDR_WIDTH-1:0] m_wr_q;
    logic [LEN_WIDTH-1:0]      m_len_q;
    logic [M_TAG_WIDTH-1:0]    m_tag_q;
    logic                      m_valid_q;
    logic                      st_valid_q;
    logic [TAG_WIDTH-1:0]      st_tag_q;

    logic [CNT_WIDTH-1:0]      cnt;
    logic                      cnt_full;
    logic [CNT_WIDTH:0]        cnt_after;
    logic                      dec_eff;
    logic                      room;
    logic                      fire;
    logic                      accept;
    logic                      load;
    logic                      in_idle;

    logic [AXI_ADDR_WIDTH-1:0] src_rd;
    logic [AXI_ADDR_WIDTH-1:0] src_wr;
    logic [LEN_WIDTH-1:0]      src_rem;
    logic [M_TAG_WIDTH-1:0]    src_idx;
    logic [LEN_WIDTH-1:0]      seg_len;

    axi_cdma_credit_cnt #(
        .MAX_COUNT (MAX_OUTSTANDING),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_credit (
        .clk   (clk),
        .rst   (rst),
        .inc   (fire),
        .dec   (s_axis_desc_status_valid),
        .count (cnt),
        .full  (cnt_full)
    );

    assign in_idle = (state_q == ST_IDLE);
    assign accept  = in_idle && s_axis_desc_valid;
    assign fire    = m_valid_q && m_axis_desc_ready;
    assign dec_eff = s_axis_desc_status_valid && (cnt != '0);

    // Look at the count as it will be after this edge so segments can issue
    // back to back and a completion frees a slot immediately.
    assign cnt_after = {1'b0, cnt} + (CNT_WIDTH+1)'(fire) - (CNT_WIDTH+1)'(dec_eff);
    assign room      = !(cnt_full && !dec_eff)
                       && (cnt_after < (CNT_WIDTH+1)'(MAX_OUTSTANDING));

    // The first segment is cut straight from the input descriptor.
    assign src_rd  = in_idle ? s_axis_desc_read_addr  : nxt_rd_q;
    assign src_wr  = in_idle ? s_axis_desc_write_addr : nxt_wr_q;
    assign src_rem = in_idle ? s_axis_desc_len        : nxt_rem_q;
    assign src_idx = in_idle ? '0                     : nxt_idx_q;
    assign seg_len = (src_rem > SEG_LEN_L) ? SEG_LEN_L : src_rem;

    assign load = (accept || (state_q == ST_ISSUE)) && (src_rem != '0)
                  && (!m_valid_q || m_axis_desc_ready) && room;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            m_valid_q  <= 1'b0;
            st_valid_q <= 1'b0;
            nxt_idx_q  <= '0;
        end else begin
            st_valid_q <= 1'b0;
            if (fire) begin
                m_valid_q <= 1'b0;
            end
            if (load) begin
                m_rd_q    <= src_rd;
                m_wr_q    <= src_wr;
                m_len_q   <= seg_len;
                m_tag_q   <= src_idx;
                m_valid_q <= 1'b1;
                nxt_rd_q  <= src_rd + AXI_ADDR_WIDTH'(seg_len);
                nxt_wr_q  <= src_wr + AXI_ADDR_WIDTH'(seg_len);
                nxt_rem_q <= src_rem - seg_len;
                nxt_idx_q <= src_idx + 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (s_axis_desc_valid) begin
                        tag_q <= s_axis_desc_tag;
                        if (!load) begin
                            nxt_rd_q  <= s_axis_desc_read_addr;
                            nxt_wr_q  <= s_axis_desc_write_addr;
                            nxt_rem_q <= s_axis_desc_len;
                            nxt_idx_q <= '0;
                        end
                        state_q <= (s_axis_desc_len != '0) ? ST_ISSUE : ST_STATUS;
                    end
                end
                ST_ISSUE: begin
                    if (fire && (nxt_rem_q == '0)) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (cnt == '0) begin
                        state_q <= ST_STATUS;
                    end
                end
                ST_STATUS: begin
                    st_valid_q <= 1'b1;
                    st_tag_q   <= tag_q;
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign s_axis_desc_ready        = in_idle;
    assign busy                     = !in_idle;
    assign m_axis_desc_read_addr    = m_rd_q;
    assign m_axis_desc_write_addr   = m_wr_q;
    assign m_axis_desc_len          = m_len_q;
    assign m_axis_desc_tag          = m_tag_q;
    assign m_axis_desc_valid        = m_valid_q;
    assign m_axis_desc_status_tag   = st_tag_q;
    assign m_axis_desc_status_valid = st_valid_q;

endmodule
